masked_cam: RTL and testbench



---
 rtl/masked_cam.sv | 153 +++++++++++++++
 tb/tb_masked_cam.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_cam.sv
// Masked (ternary-key) CAM with per-entry valid bits and a two-stage search pipeline.
// The search reports the lowest matching index, a multi-hit flag and a match count.
module masked_cam #(
  parameter int INDEX_WIDTH = 5,
  parameter int DEPTH       = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic [DATA_WIDTH-1:0]  write_data,
  input  logic                   invalidate,
  input  logic [INDEX_WIDTH-1:0] invalidate_index,
  input  logic                   flush,
  input  logic                   read,
  input  logic [INDEX_WIDTH-1:0] read_index,
  output logic [DATA_WIDTH-1:0]  read_value,
  output logic                   read_valid,
  input  logic                   search,
  input  logic [DATA_WIDTH-1:0]  search_data,
  input  logic [DATA_WIDTH-1:0]  search_mask,
  output logic                   search_valid,
  output logic                   search_hit,
  output logic [INDEX_WIDTH-1:0] search_index,
  output logic                   search_multi,
  output logic [INDEX_WIDTH:0]   search_count,
  output logic [INDEX_WIDTH:0]   entry_count,
  output logic                   full
);

  localparam logic [INDEX_WIDTH:0] DEPTH_L = (INDEX_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]       valid;
  logic [DEPTH-1:0]       valid_nxt;
  logic [INDEX_WIDTH:0]   count_nxt;

  logic                   write_ok;
  logic                   inv_ok;
  logic                   read_ok;

  logic [DEPTH-1:0]       match_vec;
  logic [DEPTH-1:0]       s1_match;
  logic                   s1_valid;

  logic                   enc_hit;
  logic [INDEX_WIDTH-1:0] enc_index;
  logic [INDEX_WIDTH:0]   enc_count;

  assign write_ok = write      && ({1'b0, write_index}      < DEPTH_L);
  assign inv_ok   = invalidate && ({1'b0, invalidate_index} < DEPTH_L);
  assign read_ok  = read       && ({1'b0, read_index}       < DEPTH_L);

  // Flush wins over everything; invalidate wins over a same-index write.
  always_comb begin
    valid_nxt = valid;
    if (write_ok) valid_nxt[write_index] = 1'b1;
    if (inv_ok)   valid_nxt[invalidate_index] = 1'b0;
    if (flush)    valid_nxt = '0;
  end

  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_nxt = count_nxt + {{INDEX_WIDTH{1'b0}}, valid_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid       <= '0;
      entry_count <= '0;
      full        <= 1'b0;
    end else begin
      valid       <= valid_nxt;
      entry_count <= count_nxt;
      full        <= (count_nxt == DEPTH_L);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_ok) begin
      mem[write_index] <= write_data;
    end
  end

  // Read samples the pre-edge array, giving read-before-write on a shared index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_value <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read_ok && valid[read_index];
      if (read) begin
        read_value <= read_ok ? mem[read_index] : '0;
      end
    end
  end

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid[i] && (((mem[i] ^ search_data) & search_mask) == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_match <= '0;
    end else begin
      s1_valid <= search;
      s1_match <= match_vec;
    end
  end

  // Walk downward so the lowest matching index is the one left standing.
  always_comb begin
    enc_hit   = |s1_match;
    enc_index = '1;
    enc_count = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (s1_match[i]) enc_index = INDEX_WIDTH'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      enc_count = enc_count + {{INDEX_WIDTH{1'b0}}, s1_match[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      search_valid <= 1'b0;
      search_hit   <= 1'b0;
      search_index <= '1;
      search_multi <= 1'b0;
      search_count <= '0;
    end else begin
      search_valid <= s1_valid;
      if (s1_valid) begin
        search_hit   <= enc_hit;
        search_index <= enc_index;
        search_multi <= (enc_count > (INDEX_WIDTH + 1)'(1));
        search_count <= enc_count;
      end
    end
  end

endmodule

// File: tb/tb_masked_cam.sv
// Directed bench for masked_cam; search results go through an expected-result queue
// that a negedge monitor drains whenever search_valid is seen.
module tb_masked_cam;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  write_index = '0;
  logic [31:0] write_data = '0;
  logic        invalidate = 1'b0;
  logic [4:0]  invalidate_index = '0;
  logic        flush = 1'b0;
  logic        read = 1'b0;
  logic [4:0]  read_index = '0;
  logic [31:0] read_value;
  logic        read_valid;
  logic        search = 1'b0;
  logic [31:0] search_data = '0;
  logic [31:0] search_mask = '1;
  logic        search_valid;
  logic        search_hit;
  logic [4:0]  search_index;
  logic        search_multi;
  logic [5:0]  search_count;
  logic [5:0]  entry_count;
  logic        full;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       hit;
    logic [4:0] idx;
    logic       multi;
    logic [5:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  masked_cam #(.INDEX_WIDTH(5), .DEPTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .write(write), .write_index(write_index), .write_data(write_data),
    .invalidate(invalidate), .invalidate_index(invalidate_index),
    .flush(flush),
    .read(read), .read_index(read_index),
    .read_value(read_value), .read_valid(read_valid),
    .search(search), .search_data(search_data), .search_mask(search_mask),
    .search_valid(search_valid), .search_hit(search_hit),
    .search_index(search_index), .search_multi(search_multi),
    .search_count(search_count),
    .entry_count(entry_count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_search(input logic hit, input logic [4:0] idx,
                               input logic multi, input logic [5:0] cnt);
    exp_t e;
    e.hit = hit; e.idx = idx; e.multi = multi; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] data);
    write = 1'b1; write_index = idx; write_data = data;
    step();
    write = 1'b0;
  endtask

  task automatic rd_check(input logic [4:0] idx, input logic [31:0] val, input logic vld,
                          input string name);
    read = 1'b1; read_index = idx;
    step();
    read = 1'b0;
    chk({name, ".value"}, 64'(read_value), 64'(val));
    chk({name, ".valid"}, 64'(read_valid), 64'(vld));
  endtask

  always @(negedge clk) begin
    if (rst && search_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_search_valid", 64'(search_valid), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("search_hit",   64'(search_hit),   64'(e.hit));
        chk("search_index", 64'(search_index), 64'(e.idx));
        chk("search_multi", 64'(search_multi), 64'(e.multi));
        chk("search_count", 64'(search_count), 64'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst.read_value",   64'(read_value),   64'(0));
    chk("rst.read_valid",   64'(read_valid),   64'(0));
    chk("rst.search_valid", 64'(search_valid), 64'(0));
    chk("rst.search_index", 64'(search_index), 64'(31));
    chk("rst.entry_count",  64'(entry_count),  64'(0));
    chk("rst.full",         64'(full),         64'(0));
    @(negedge clk);
    rst = 1'b1;
    step();

    // idle search on an empty table
    search = 1'b1; search_data = 32'h0; search_mask = '1;
    expect_search(1'b0, 5'd31, 1'b0, 6'd0);
    step();
    search = 1'b0;
    step();
    step();
    chk("t1.entry_count", 64'(entry_count), 64'(0));

    // write then read + search
    wr(5'd9, 32'd7);
    read = 1'b1; read_index = 5'd9;
    search = 1'b1; search_data = 32'd7; search_mask = '1;
    expect_search(1'b1, 5'd9, 1'b0, 6'd1);
    step();
    read = 1'b0; search = 1'b0;
    chk("t2.read_value", 64'(read_value), 64'(7));
    chk("t2.read_valid", 64'(read_valid), 64'(1));
    // read-before-write on the same index
    read = 1'b1; read_index = 5'd9;
    write = 1'b1; write_index = 5'd9; write_data = 32'h1234;
    step();
    read = 1'b0; write = 1'b0;
    chk("t2.rbw_value", 64'(read_value), 64'(7));
    rd_check(5'd9, 32'h1234, 1'b1, "t2.after_write");
    wr(5'd9, 32'd7);

    // masked searches; 0x35 differs from 0x15 in bit 5 so only the DD mask admits it
    wr(5'd3, 32'h15);
    wr(5'd12, 32'h17);
    wr(5'd20, 32'h35);
    search = 1'b1; search_data = 32'h15; search_mask = 32'hFFFF_FFFD;
    expect_search(1'b1, 5'd3, 1'b1, 6'd2);
    step();
    search_mask = 32'hFFFF_FFDD;
    expect_search(1'b1, 5'd3, 1'b1, 6'd3);
    step();
    search_data = 32'hDEAD_BEEF; search_mask = 32'h0;
    expect_search(1'b1, 5'd3, 1'b1, 6'd4);
    step();
    search = 1'b0;
    chk("t3.entry_count", 64'(entry_count), 64'(4));

    // back-to-back searches 7, 8, 7
    search = 1'b1; search_mask = '1;
    for (int k = 0; k < 3; k++) begin
      search_data = (k == 1) ? 32'd8 : 32'd7;
      if (k == 1) expect_search(1'b0, 5'd31, 1'b0, 6'd0);
      else        expect_search(1'b1, 5'd9, 1'b0, 6'd1);
      step();
    end
    search = 1'b0;

    // write and invalidate on one edge: same index, then different indices
    write = 1'b1; write_index = 5'd4; write_data = 32'hAB;
    invalidate = 1'b1; invalidate_index = 5'd4;
    step();
    write = 1'b0; invalidate = 1'b0;
    rd_check(5'd4, 32'hAB, 1'b0, "wi_same");
    chk("wi_same.entry_count", 64'(entry_count), 64'(4));
    write = 1'b1; write_index = 5'd5; write_data = 32'h55;
    invalidate = 1'b1; invalidate_index = 5'd3;
    step();
    write = 1'b0; invalidate = 1'b0;
    chk("wi_diff.entry_count", 64'(entry_count), 64'(4));
    rd_check(5'd3, 32'h15, 1'b0, "wi_diff.inv");
    rd_check(5'd5, 32'h55, 1'b1, "wi_diff.wr");

    // search sees the pre-edge table when invalidated on the same edge
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5.flush_count", 64'(entry_count), 64'(0));
    wr(5'd9, 32'd7);
    chk("t5.entry_count1", 64'(entry_count), 64'(1));
    search = 1'b1; search_data = 32'd7; search_mask = '1;
    invalidate = 1'b1; invalidate_index = 5'd9;
    expect_search(1'b1, 5'd9, 1'b0, 6'd1);
    step();
    invalidate = 1'b0;
    chk("t5.entry_count0", 64'(entry_count), 64'(0));
    expect_search(1'b0, 5'd31, 1'b0, 6'd0);
    step();
    search = 1'b0;
    step();
    step();

    // fill the table, search it, then flush while that search is in flight
    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i + 100));
    chk("t6.entry_count", 64'(entry_count), 64'(32));
    chk("t6.full", 64'(full), 64'(1));
    search = 1'b1; search_data = 32'h0; search_mask = 32'h0;
    expect_search(1'b1, 5'd0, 1'b1, 6'd32);
    step();
    search = 1'b0;
    flush = 1'b1; write = 1'b1; write_index = 5'd0; write_data = 32'd5;
    step();
    flush = 1'b0; write = 1'b0;
    chk("t6.flush_full", 64'(full), 64'(0));
    chk("t6.flush_count", 64'(entry_count), 64'(0));
    rd_check(5'd0, 32'd5, 1'b0, "t6.read0");
    step();
    step();

    // reset one cycle after a launch: the in-flight search must vanish
    wr(5'd2, 32'h77);
    read = 1'b1; read_index = 5'd2;
    search = 1'b1; search_data = 32'h77; search_mask = '1;
    step();
    search = 1'b0; read = 1'b0;
    rst = 1'b0;
    #1;
    chk("t7.read_value",   64'(read_value),   64'(0));
    chk("t7.read_valid",   64'(read_valid),   64'(0));
    chk("t7.search_valid", 64'(search_valid), 64'(0));
    chk("t7.search_hit",   64'(search_hit),   64'(0));
    chk("t7.search_multi", 64'(search_multi), 64'(0));
    chk("t7.search_count", 64'(search_count), 64'(0));
    chk("t7.search_index", 64'(search_index), 64'(31));
    chk("t7.entry_count",  64'(entry_count),  64'(0));
    chk("t7.full",         64'(full),         64'(0));
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    step();
    chk("t7.after_valid", 64'(search_valid), 64'(0));
    rd_check(5'd2, 32'h0, 1'b0, "t7.data_cleared");

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
